// File: rtl/seq_alu.sv
// seq_alu: registered MIPS ALU with sequential MULTU and optional DIVU (enable with ALU_DIV_EN)
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] opr, ph, pl, h_n, l_n;
  logic [WIDTH-1:0] add_r, sub_r, bn, res, mh_n, ml_n;
  logic [WIDTH:0] msum;
  logic ovf, go, last, is_mc;
  assign go    = Start && state == IDLE;
  assign last  = cnt == CW'(1);
  assign Busy  = state != IDLE;
`ifdef ALU_DIV_EN
  logic [WIDTH:0] dt;
  logic [WIDTH-1:0] dd, dh_n, dl_n;
  logic dge;
  assign is_mc = ALUOperation == 4'd8 || ALUOperation == 4'd9;
`else
  assign is_mc = ALUOperation == 4'd8;
`endif
  // single-cycle result and signed overflow
  always_comb begin
    add_r = A + B;
    bn    = ~B + 1'b1;
    sub_r = A + bn;
    res   = '0;
    ovf   = 1'b0;
    case (ALUOperation)
      4'd0: res = A & B;
      4'd1: res = A | B;
      4'd2: res = ~(A | B);
      4'd3: begin
        res = add_r;
        ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_r[WIDTH-1] != A[WIDTH-1]);
      end
      4'd4: begin
        res = sub_r;
        ovf = (A[WIDTH-1] == bn[WIDTH-1]) && (sub_r[WIDTH-1] != A[WIDTH-1]);
      end
      4'd5: res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'd6: res = A << B[SHW-1:0];
      4'd7: res = A >> B[SHW-1:0];
      default: res = '0;
    endcase
  end
  // one shift-add multiplier step and one restoring-divider step
  always_comb begin
    msum = {1'b0, ph} + (pl[0] ? {1'b0, opr} : '0);
    mh_n = msum[WIDTH:1];
    ml_n = {msum[0], pl[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    dt   = {ph, pl[WIDTH-1]};
    dge  = dt >= {1'b0, opr};
    dd   = dt[WIDTH-1:0] - opr;
    dh_n = dge ? dd : dt[WIDTH-1:0];
    dl_n = {pl[WIDTH-2:0], dge};
    h_n  = state == DIV ? dh_n : mh_n;
    l_n  = state == DIV ? dl_n : ml_n;
`else
    h_n  = mh_n;
    l_n  = ml_n;
`endif
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt;
  // next-state: multi-cycle ops leave IDLE, return after the last iteration
  always_comb begin
    nxt = state;
    if (go && ALUOperation == 4'd8) nxt = MUL;
`ifdef ALU_DIV_EN
    if (go && ALUOperation == 4'd9) nxt = DIV;
`endif
    if (state != IDLE && last) nxt = IDLE;
  end
  // datapath: operand capture, iterations and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      opr       <= '0;
      ph        <= '0;
      pl        <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (go && is_mc) begin
        opr <= ALUOperation == 4'd8 ? A : B;
        pl  <= ALUOperation == 4'd8 ? B : A;
        ph  <= '0;
        cnt <= CW'(WIDTH);
      end else if (go) begin
        ALUResult <= res;
        Zero      <= res == '0;
        Overflow  <= ovf;
        Done      <= 1'b1;
      end else if (state != IDLE) begin
        ph  <= h_n;
        pl  <= l_n;
        cnt <= cnt - CW'(1);
        if (last) begin
          HI        <= h_n;
          LO        <= l_n;
          ALUResult <= l_n;
          Zero      <= state == MUL ? {h_n, l_n} == '0 : l_n == '0;
          Overflow  <= 1'b0;
          Done      <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu
module tb_seq_alu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic Start = 1'b0;
  logic [3:0] ALUOperation = '0;
  logic [31:0] A = '0, B = '0;
  logic Busy, Done, Zero, Overflow;
  logic [31:0] ALUResult, HI, LO;
  int nvec = 0, nerr = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .ALUResult(ALUResult),
    .Zero(Zero), .Overflow(Overflow), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    ALUOperation = opc;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_timeout", Done, 1);
  endtask

  initial begin
    int bc;
    logic both;
    #12;
    chk("rst_res", ALUResult, 0);
    chk("rst_flags", {Zero, Overflow, Busy, Done}, 4'b1000);
    chk("rst_hilo", {HI, LO}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op(4'd3, 32'h7FFF_FFFF, 32'h1);
    chk("add_res", ALUResult, 32'h8000_0000);
    chk("add_flags", {Overflow, Zero, Done, Busy}, 4'b1010);
    @(posedge clk);
    #1;
    chk("add_done_drop", Done, 0);
    op(4'd4, 32'd5, 32'd5);
    chk("sub_flags", {Zero, Overflow, Done}, 3'b101);
    op(4'd5, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", ALUResult, 1);
    chk("slt_flags", {Zero, Done, Busy}, 3'b010);
    op(4'd4, 32'h8000_0000, 32'h1);
    chk("sub_ovf", {ALUResult, 31'd0, Overflow}, {32'h7FFF_FFFF, 32'h1});
    op(4'd6, 32'h1, 32'd31);
    chk("sll", ALUResult, 32'h8000_0000);
    op(4'd7, 32'h8000_0000, 32'd31);
    chk("srl", ALUResult, 1);
    op(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and", ALUResult, 32'h0000_F000);
    op(4'd1, 32'h0000_F0F0, 32'h0000_FF00);
    chk("or", ALUResult, 32'h0000_FFF0);
    op(4'd2, 32'h0, 32'h0);
    chk("nor", ALUResult, 32'hFFFF_FFFF);
    op(4'd12, 32'h5, 32'h3);
    chk("unsup", {ALUResult, 29'd0, Zero, Overflow, Busy}, {32'h0, 32'h4});
    chk("hilo_kept", {HI, LO}, 0);
    op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bc = 1;
    both = 1'b0;
    chk("mul_busy0", {Busy, Done}, 2'b10);
    while (Busy && bc < 100) begin
      if (bc == 5) begin
        Start = 1'b1;
        ALUOperation = 4'd0;
        A = 32'h0;
        B = 32'h0;
      end
      if (bc == 8) Start = 1'b0;
      @(posedge clk);
      #1;
      if (Busy && Done) both = 1'b1;
      if (Busy) bc++;
    end
    chk("mul_busy_cycles", bc, 32);
    chk("mul_never_both", both, 0);
    chk("mul_done", Done, 1);
    chk("mul_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    chk("mul_res", {ALUResult, 30'd0, Zero, Overflow}, {32'h1, 32'h0});
    @(posedge clk);
    #1;
    chk("mul_done_drop", Done, 0);
    op(4'd0, 32'h0000_FFFF, 32'h0000_0F0F);
    chk("and_after_mul", ALUResult, 32'h0000_0F0F);
    chk("hilo_after_and", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
`ifdef ALU_DIV_EN
    op(4'd9, 32'd100, 32'd7);
    chk("div_busy", Busy, 1);
    wait_done();
    chk("div_hilo", {HI, LO}, {32'd2, 32'd14});
    chk("div_res", {ALUResult, 31'd0, Zero}, {32'd14, 32'd0});
    @(negedge clk);
    op(4'd9, 32'd9, 32'd0);
    wait_done();
    chk("div0_hilo", {HI, LO}, {32'd9, 32'hFFFF_FFFF});
`else
    op(4'd9, 32'd100, 32'd7);
    chk("op9_res", ALUResult, 0);
    chk("op9_flags", {Zero, Busy, Done}, 3'b101);
    chk("op9_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
`endif
    @(negedge clk);
    op(4'd8, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_res", ALUResult, 0);
    chk("midrst_flags", {Zero, Overflow, Busy, Done}, 4'b1000);
    chk("midrst_hilo", {HI, LO}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op(4'd8, 32'd3, 32'd4);
    wait_done();
    chk("mul34_hilo", {HI, LO}, 64'd12);
    chk("mul34_res", {ALUResult, 31'd0, Zero}, {32'd12, 32'd0});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the MIPS datapath, replacing the purely combinational ALU.
- Adds signed overflow, set-less-than and shifts to the logic and arithmetic set.
- Adds a sequential unsigned multiplier writing HI/LO, with an optional sequential unsigned divider.
- Sits in the execute stage; the control unit drives a start/busy/done handshake and stalls on Busy.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8; SHW = $clog2(WIDTH)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Start  input  1  operation request, sampled on the rising edge of clk while Busy=0
- ALUOperation  input  4  opcode, sampled with Start
- A  input  WIDTH  operand A, sampled with Start
- B  input  WIDTH  operand B, sampled with Start; B[SHW-1:0] is the shift amount
- Busy  output  1  multi-cycle operation in progress
- Done  output  1  one-cycle pulse: results valid
- ALUResult  output  WIDTH  registered result
- Zero  output  1  registered, ALUResult==0 (MULTU: {HI,LO}==0)
- Overflow  output  1  signed overflow of ADD/SUB, 0 for all other ops
- HI  output  WIDTH  upper product / remainder
- LO  output  WIDTH  lower product / quotient

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB: ADD/SUB wrap modulo 2^WIDTH.
  - 5 SLT: signed, result 1 or 0.
  - 6 SLL, 7 SRL: logical, shift by B[SHW-1:0].
  - 8 MULTU, 9 DIVU.
  - 10–15: unsupported; ALUResult=0, Zero=1, Overflow=0, HI/LO unchanged.
- Overflow = (A[MSB]==B'[MSB]) && (R[MSB]!=A[MSB]), where B'=B for ADD and ~B+1 for SUB.
- States:
  - IDLE: Start with opcode other than 8/9 executes in one cycle and stays in IDLE. Start with 8 goes to MUL; Start with 9 goes to DIV.
  - MUL: shift-add, one multiplier bit per cycle, iteration counter WIDTH→0. At count 0: writes {HI,LO} = A×B (unsigned, 2·WIDTH bits), ALUResult=LO, Zero={HI,LO}==0, Overflow=0, then returns to IDLE.
  - DIV: restoring division, one quotient bit per cycle. Ends with LO=A/B, HI=A%B, ALUResult=LO, Zero=(LO==0), then returns to IDLE.
- Divide by zero is not trapped. It yields LO = all ones and HI = A.
- Start while Busy=1 is ignored; operands and opcode are not re-sampled.
- HI/LO change only on MULTU/DIVU completion; single-cycle ops leave them unchanged.
- ALUResult, Zero and Overflow hold their last value between operations.

## Timing
- Reset (reset=0, asynchronous) forces:
  - IDLE; ALUResult=0, Zero=1, Overflow=0, HI=0, LO=0, Busy=0, Done=0.
  - Reset mid-operation aborts the MUL/DIV with no partial result exposed.
- Single-cycle ops, Start accepted at edge 0:
  - ALUResult/Zero/Overflow update at edge 0.
  - Done=1 from edge 0 to edge 1.
  - Busy stays 0.
- Back-to-back single-cycle Starts are accepted every cycle; Done stays high continuously.
- MULTU/DIVU, Start accepted at edge 0:
  - Busy=1 from edge 0.
  - Iterations run at edges 1..WIDTH.
  - At edge WIDTH: results written, Busy=0, Done=1 for one cycle.
  - Latency is WIDTH cycles.
  - A new Start is accepted at edge WIDTH+1 at the earliest. Start is not sampled at edge WIDTH, because Busy=1 before that edge.
- Done and Busy are never both 1.

## Configuration
- ALU_DIV_EN defined:
  - opcode 9 runs the DIVU state as above.
- ALU_DIV_EN undefined:
  - DIV state and divider datapath are not compiled.
  - Opcode 9 behaves as unsupported: single cycle, ALUResult=0, Zero=1, Done pulse, HI/LO unchanged, Busy stays 0.

## Test plan
- ADD 0x7FFFFFFF+1 → ALUResult=0x80000000, Overflow=1, Zero=0, Done one cycle after Start, Busy never 1.
- SUB 5−5 then SLT −1<1 in back-to-back cycles → Zero=1; then ALUResult=1; Done high both cycles.
- SLL 0x1 by 31, then SRL 0x80000000 by 31 → 0x80000000, then 0x1; HI/LO unchanged.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001.
  - Busy high exactly 32 cycles; Done at edge 32.
  - Start pulsed mid-operation is ignored.
- DIVU (ALU_DIV_EN):
  - 100/7 → LO=14, HI=2.
  - 9/0 → LO=0xFFFFFFFF, HI=9.
  - Without the macro, opcode 9 → ALUResult=0, Zero=1, Busy=0.
- Reset asserted at MUL iteration 10 → all outputs at reset values immediately; after release, a fresh MULTU 3×4 gives LO=12, HI=0.
